// File: rtl/led_seq_pkg.sv
// Shared mode/direction encodings and seed helpers for the LED pattern sequencer.
package led_seq_pkg;

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_CHASE  = 3'd1,
    MODE_BOUNCE = 3'd2,
    MODE_BLINK  = 3'd3,
    MODE_FILL   = 3'd4
  } mode_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Seeds are built at this width and truncated to the bank width by the caller.
  localparam int SEED_MAX = 64;

  function automatic logic mode_valid(logic [2:0] m);
    return m <= 3'd4;
  endfunction

  function automatic logic [SEED_MAX-1:0] mode_seed(logic [2:0] m, int width);
    case (m)
      MODE_CHASE, MODE_BOUNCE, MODE_FILL: return SEED_MAX'(1);
      MODE_BLINK: return {SEED_MAX{1'b1}} >> (SEED_MAX - width);
      default:    return '0;
    endcase
  endfunction

endpackage

// File: rtl/tick_divider.sv
// Programmable divider: terminal count every period+1 unheld clocks, freezes at terminal under hold.
module tick_divider #(
  parameter int DIV_W = 24
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             hold,
  input  logic [DIV_W-1:0] period,
  output logic             tc
);

  logic [DIV_W-1:0] cnt;
  logic             at_term;

  assign at_term = (cnt == period);
  assign tc      = at_term & ~hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     cnt <= '0;
    else if (clear) cnt <= '0;
    else if (!hold) cnt <= at_term ? '0 : cnt + 1'b1;
  end

endmodule

// File: rtl/led_sequencer.sv
// LED bank pattern controller: config handshake, mode/dir state and per-tick pattern advance.
module led_sequencer
  import led_seq_pkg::*;
#(
  parameter int WIDTH      = 18,
  parameter int DIV_W      = 24,
  parameter int DEF_PERIOD = 500000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [2:0]       cfg_mode,
  input  logic [DIV_W-1:0] cfg_period,
  input  logic             hold,
  output logic             cfg_err,
  output logic             tick,
  output logic [WIDTH-1:0] pins
);

  mode_t            mode_q, mode_d;
  dir_t             dir_q, dir_d;
  logic [DIV_W-1:0] period_q, period_d;
  logic [WIDTH-1:0] pins_d;
  logic             tick_d, err_d, rdy_d;
  logic             xfer, accept, reject, tc;

  assign xfer   = cfg_valid & cfg_ready;
  assign accept = xfer & mode_valid(cfg_mode);
  assign reject = xfer & ~mode_valid(cfg_mode);

  tick_divider #(.DIV_W(DIV_W)) u_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .hold   (hold),
    .period (period_q),
    .tc     (tc)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q    <= MODE_OFF;
      dir_q     <= DIR_UP;
      period_q  <= DIV_W'(DEF_PERIOD);
      pins      <= '0;
      tick      <= 1'b0;
      cfg_err   <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      mode_q    <= mode_d;
      dir_q     <= dir_d;
      period_q  <= period_d;
      pins      <= pins_d;
      tick      <= tick_d;
      cfg_err   <= err_d;
      cfg_ready <= rdy_d;
    end
  end

  // A config load takes priority over a coincident terminal count.
  always_comb begin
    mode_d   = mode_q;
    dir_d    = dir_q;
    period_d = period_q;
    pins_d   = pins;
    tick_d   = 1'b0;
    err_d    = reject;
    rdy_d    = ~accept;
    if (accept) begin
      mode_d   = mode_t'(cfg_mode);
      period_d = cfg_period;
      pins_d   = WIDTH'(mode_seed(cfg_mode, WIDTH));
      dir_d    = DIR_UP;
    end else if (tc) begin
      tick_d = 1'b1;
      case (mode_q)
        MODE_CHASE: pins_d = {pins[WIDTH-2:0], pins[WIDTH-1]};
        MODE_BOUNCE: begin
          // Flip as the lit bit lands on an end so the end is shown for one tick only.
          if (dir_q == DIR_UP) begin
            pins_d = pins << 1;
            if (pins[WIDTH-2]) dir_d = DIR_DOWN;
          end else begin
            pins_d = pins >> 1;
            if (pins[1]) dir_d = DIR_UP;
          end
        end
        MODE_BLINK: pins_d = ~pins;
        MODE_FILL:  pins_d = (&pins) ? '0 : {pins[WIDTH-2:0], 1'b1};
        default:    pins_d = '0;
      endcase
    end
  end

endmodule
